button_encoder: RTL and testbench
=================================

BUTTON_ENCODER -- requirements
Module: button_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, the number of consecutive stable synchronized samples required to accept a press or a release (minimum 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 24'd10000000, the continuous single-button hold length that raises START_GAME (used only under REQ-025).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port BTN  input  4  raw asynchronous push-buttons, active-high; BTN[n] is colour n.
REQ-006 SHALL have port ENABLE  input  1  when high, accepted presses produce KEY_VALID.
REQ-007 SHALL have port KEY  output  2  encoded colour of the last accepted press; drives the game controller IN.
REQ-008 SHALL have port KEY_VALID  output  1  single-cycle strobe qualifying KEY; drives the game controller IN_VALID.
REQ-009 SHALL have port START_GAME  output  1  single-cycle start request; drives the game controller START_GAME.

Function
REQ-010 SHALL pass each BTN bit through a two-flop synchronizer before any other use; S denotes the synchronized 4-bit vector.
REQ-011 SHALL implement states IDLE, PRESS_DB, WAIT_REL, REL_DB.
REQ-012 IDLE: on S != 0, SHALL capture CAND <= S, clear the stability counter, and go to PRESS_DB.
REQ-013 PRESS_DB: if S == 0, SHALL go to IDLE; if S != CAND and S != 0, SHALL recapture CAND and clear the counter; otherwise SHALL increment the counter.
REQ-014 PRESS_DB: when the counter reaches DEBOUNCE_CYCLES-1 with S == CAND, SHALL go to WAIT_REL and accept CAND.
REQ-015 An accepted CAND that is one-hot SHALL load KEY with the bit index (0001->0, 0010->1, 0100->2, 1000->3) and, if ENABLE is high that cycle, SHALL pulse KEY_VALID for exactly one cycle.
REQ-016 An accepted CAND with more than one bit set SHALL be rejected: no KEY update, no KEY_VALID, still WAIT_REL.
REQ-017 WAIT_REL: on S == 0, SHALL clear the counter and go to REL_DB.
REQ-018 REL_DB: any S != 0 SHALL return to WAIT_REL; S == 0 for DEBOUNCE_CYCLES consecutive cycles SHALL go to IDLE.
REQ-019 SHALL emit at most one KEY_VALID per press-release cycle; a held button never repeats.
REQ-020 Total latency SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 from a clean BTN edge to KEY_VALID high.
REQ-021 KEY SHALL hold its value between strobes; KEY_VALID and START_GAME SHALL be low in every cycle they are not pulsed.
REQ-022 The counter SHALL saturate, never wrap, and be wide enough for max(DEBOUNCE_CYCLES, HOLD_CYCLES).
REQ-023 ENABLE falling while in WAIT_REL SHALL have no effect; ENABLE is sampled only on the acceptance cycle.

Reset
REQ-024 RST high SHALL force, on the next edge: synchronizer flops 0, state IDLE, counters 0, CAND 0, KEY 2'b00, KEY_VALID 0, START_GAME 0. Reset mid-press SHALL discard the press; a button still held after reset SHALL be debounced afresh as a new press.

Configuration
REQ-025 With START_HOLD_EN defined: in WAIT_REL, after a one-hot accept, a second counter SHALL count while S == CAND and pulse START_GAME once upon reaching HOLD_CYCLES-1, regardless of ENABLE; no further pulse until release. Rejected multi-presses SHALL never start the count.
REQ-026 Without START_HOLD_EN: START_GAME SHALL be constant 0 and no hold counter SHALL be synthesized.

Structure
REQ-027 The state encoding (BTN_IDLE_S, BTN_PRESS_DB_S, BTN_WAIT_REL_S, BTN_REL_DB_S) SHALL live in the shared constants include next to the controller state constants.
REQ-028 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-029 BTN=0100 held 20 cycles then 0 -> exactly one KEY_VALID, 7 cycles after the edge, with KEY=2.
REQ-030 BTN=0001 bouncing 1/0 every 2 cycles for 10 cycles, then stable -> no KEY_VALID during bounce; one strobe with KEY=0 after 4 stable cycles.
REQ-031 BTN=0011 held 10 cycles -> no KEY_VALID; KEY keeps its prior value; next BTN=1000 press -> KEY=3 strobe.
REQ-032 ENABLE=0 with BTN=0010 pressed -> no KEY_VALID, KEY=1; release and press again with ENABLE=1 -> one strobe.
REQ-033 RST pulsed in PRESS_DB with BTN=1000 held -> outputs zero; after reset, a strobe with KEY=3 occurs 7 cycles after RST falls.
REQ-034 START_HOLD_EN: BTN=0001 held 30 cycles -> one KEY_VALID, then one START_GAME pulse; without the macro START_GAME stays 0.

Source files
------------

// File: rtl/button_encoder_pkg.sv
// button_encoder_pkg: shared state encodings and helpers for the button front end and game controller.
package button_encoder_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE_S,
        BTN_PRESS_DB_S,
        BTN_WAIT_REL_S,
        BTN_REL_DB_S
    } btn_state_e;

    typedef enum logic [2:0] {
        CTRL_IDLE_S,
        CTRL_SHOW_S,
        CTRL_INPUT_S,
        CTRL_WIN_S,
        CTRL_LOSE_S
    } ctrl_state_e;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic int cnt_width(input longint a, input longint b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/button_encoder_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, reset to zero.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_encoder.sv
// button_encoder: debounces four colour buttons into a key strobe for the game controller.
// START_HOLD_EN adds a long single-button hold that raises START_GAME.
module button_encoder
    import button_encoder_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd10000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    input  logic       ENABLE,
    output logic [1:0] KEY,
    output logic       KEY_VALID,
    output logic       START_GAME
);

    localparam int CNT_W = cnt_width(longint'(DEBOUNCE_CYCLES), longint'(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] REL_LAST = DB_LAST - CNT_W'(1);

    logic [3:0]       s;
    btn_state_e       state_q;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       key_q;
    logic             kv_q;

    sync_2ff #(.W(4)) u_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (BTN),
        .q_o  (s)
    );

    always_comb cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef START_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 24'd1);

    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             armed_q;
    logic             done_q;
    logic             sg_q;

    always_comb hold_d = (&hold_q) ? hold_q : hold_q + CNT_W'(1);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BTN_IDLE_S;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= 2'b00;
            kv_q    <= 1'b0;
`ifdef START_HOLD_EN
            hold_q  <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            sg_q    <= 1'b0;
`endif
        end else begin
            kv_q <= 1'b0;
`ifdef START_HOLD_EN
            sg_q <= 1'b0;
`endif
            case (state_q)
                BTN_IDLE_S: begin
                    if (s != 4'd0) begin
                        cand_q  <= s;
                        cnt_q   <= '0;
                        state_q <= BTN_PRESS_DB_S;
                    end
                end
                BTN_PRESS_DB_S: begin
                    if (s == 4'd0) begin
                        state_q <= BTN_IDLE_S;
                    end else if (s != cand_q) begin
                        cand_q <= s;
                        cnt_q  <= '0;
                    end else if (cnt_q >= DB_LAST) begin
                        state_q <= BTN_WAIT_REL_S;
`ifdef START_HOLD_EN
                        hold_q  <= '0;
                        done_q  <= 1'b0;
                        armed_q <= is_onehot(cand_q);
`endif
                        // Chords are swallowed here: no KEY update, but release is still awaited.
                        if (is_onehot(cand_q)) begin
                            key_q <= enc4(cand_q);
                            kv_q  <= ENABLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                BTN_WAIT_REL_S: begin
                    if (s == 4'd0) begin
                        cnt_q   <= '0;
                        state_q <= BTN_REL_DB_S;
                    end
`ifdef START_HOLD_EN
                    else if (armed_q && !done_q && s == cand_q) begin
                        if (hold_q >= HOLD_LAST) begin
                            sg_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            hold_q <= hold_d;
                        end
                    end
`endif
                end
                BTN_REL_DB_S: begin
                    // The WAIT_REL sample that saw zero counts as the first stable sample.
                    if (s != 4'd0) begin
                        state_q <= BTN_WAIT_REL_S;
                    end else if (cnt_q >= REL_LAST) begin
                        state_q <= BTN_IDLE_S;
`ifdef START_HOLD_EN
                        armed_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= BTN_IDLE_S;
            endcase
        end
    end

    assign KEY       = key_q;
    assign KEY_VALID = kv_q;
`ifdef START_HOLD_EN
    assign START_GAME = sg_q;
`else
    assign START_GAME = 1'b0;
`endif

endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: scoreboard bench for button_encoder with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_button_encoder;

    typedef struct {
        logic [1:0] key;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic       enable = 1'b1;
    logic [1:0] key;
    logic       key_valid;
    logic       start_game;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   exp_start = 0;
    exp_t sb[$];

    button_encoder #(
        .DEBOUNCE_CYCLES(16'd4),
        .HOLD_CYCLES    (24'd8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .BTN       (btn),
        .ENABLE    (enable),
        .KEY       (key),
        .KEY_VALID (key_valid),
        .START_GAME(start_game)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input bit strobe, input logic [1:0] k);
        btn = b;
        if (strobe) sb.push_back('{k, cyc + 7});
        tick(hold);
        btn = 4'd0;
        tick(12);
    endtask

    always @(negedge clk) begin
        if (start_game) start_cnt++;
        if (key_valid) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_key", int'(key), int'(e.key));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        tick(3);
        check("reset_key", int'(key), 0);
        check("reset_valid", int'(key_valid), 0);
        check("reset_start", int'(start_game), 0);
        rst = 1'b0;
        tick(2);
`ifdef START_HOLD_EN
        exp_start = 1;
`endif
        press(4'b0100, 20, 1'b1, 2'd2);
        press(4'b0011, 10, 1'b0, 2'd0);
        check("chord_keeps_key", int'(key), 2);
        press(4'b1000, 10, 1'b1, 2'd3);
        for (int i = 0; i < 10; i++) begin
            btn = (i % 4 < 2) ? 4'b0001 : 4'b0000;
            if (i == 8) sb.push_back('{2'd0, cyc + 7});
            tick(1);
        end
        press(4'b0001, 10, 1'b0, 2'd0);
        enable = 1'b0;
        btn = 4'b0010;
        tick(9);
        check("disabled_key", int'(key), 1);
        btn = 4'b0000;
        tick(12);
        enable = 1'b1;
        press(4'b0010, 10, 1'b1, 2'd1);
        btn = 4'b1000;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("midpress_reset_key", int'(key), 0);
        check("midpress_reset_valid", int'(key_valid), 0);
        rst = 1'b0;
        press(4'b1000, 10, 1'b1, 2'd3);
`ifdef START_HOLD_EN
        exp_start = 2;
`endif
        press(4'b0001, 30, 1'b1, 2'd0);
        check("start_count", start_cnt, exp_start);
        check("pending_expected", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
